cache_set_assoc: RTL and testbench

// - Parametrised N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// - Owns its miss handling: an internal FSM writes back dirty victims and refills lines. Core needs only a ready handshake.
// - Sits between the pipeline MEM stage and the block-granular main-memory port.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_lru_set.sv | 43 ++++
 rtl/cache_set_assoc.sv | 225 ++++++++++++++++++++++
 tb/tb_cache_set_assoc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: controller states and
// small arithmetic helpers used by the cache top and its LRU sub-module.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_t;

  localparam int WORD_W = 32;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU bookkeeping for one set: promotes the touched way to MRU and picks
// the replacement victim (first invalid way, else the oldest way).
module cache_lru_set #(
  parameter int WAYS = 2,
  parameter int AW   = 1
) (
  input  logic [WAYS*AW-1:0] ages,
  input  logic [WAYS-1:0]    valid,
  input  logic [AW-1:0]      touch,
  output logic [WAYS*AW-1:0] ages_next,
  output logic [AW-1:0]      victim
);

  logic [AW-1:0] touch_age_s;
  logic [AW-1:0] cur_age_s;
  logic [AW-1:0] free_way_s;
  logic [AW-1:0] old_way_s;
  logic          any_free_s;

  // Age promotion and victim selection; the downward scan leaves the lowest free way
  always_comb begin
    ages_next   = ages;
    touch_age_s = ages[int'(touch)*AW +: AW];
    cur_age_s   = '0;
    free_way_s  = '0;
    old_way_s   = '0;
    any_free_s  = ~&valid;
    for (int w = WAYS - 1; w >= 0; w--) begin
      cur_age_s = ages[w*AW +: AW];
      if (AW'(w) == touch) begin
        ages_next[w*AW +: AW] = '0;
      end else if (cur_age_s < touch_age_s) begin
        ages_next[w*AW +: AW] = cur_age_s + 1'b1;
      end else begin
        ages_next[w*AW +: AW] = cur_age_s;
      end
      free_way_s = valid[w] ? free_way_s : AW'(w);
      old_way_s  = (cur_age_s == AW'(WAYS - 1)) ? AW'(w) : old_way_s;
    end
    victim = any_free_s ? free_way_s : old_way_s;
  end

endmodule

// File: rtl/cache_set_assoc.sv
// N-way set-associative write-back / write-allocate cache with true-LRU
// replacement and an internal miss FSM talking to a block-wide memory port.
module cache_set_assoc
  import cache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 5,
  parameter int WORD_BITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_re,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_ready,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [(32 << WORD_BITS)-1:0]  mem_wblk,
  input  logic [(32 << WORD_BITS)-1:0]  mem_rblk,
  input  logic                          mem_done,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
);

  localparam int TAG_BITS = 32 - SET_BITS - WORD_BITS - 2;
  localparam int SETS     = 1 << SET_BITS;
  localparam int BLK_W    = WORD_W << WORD_BITS;
  localparam int OFF_BITS = WORD_BITS + 2;
  localparam int AW       = (WAYS > 1) ? clog2(WAYS) : 1;

  logic [TAG_BITS-1:0] tag_mem  [WAYS][SETS];
  logic [BLK_W-1:0]    data_mem [WAYS][SETS];
  logic [WAYS-1:0]     valid_r  [SETS];
  logic [WAYS-1:0]     dirty_r  [SETS];
  logic [WAYS*AW-1:0]  age_r    [SETS];

  state_t              state_r;
  state_t              state_n;
  logic [AW-1:0]       victim_r;
  logic                retry_r;
  logic [31:0]         hit_cnt_r;
  logic [31:0]         miss_cnt_r;

  logic [TAG_BITS-1:0] tag_s;
  logic [SET_BITS-1:0] idx_s;
  logic [WORD_BITS-1:0] word_s;
  logic                unused_addr_s;
  logic                req_s;
  logic [WAYS-1:0]     hit_vec_s;
  logic [AW-1:0]       hit_way_s;
  logic                hit_s;
  logic [31:0]         hit_word_s;
  logic [AW-1:0]       victim_s;
  logic                victim_dirty_s;
  logic [AW-1:0]       touch_s;
  logic [WAYS*AW-1:0]  ages_next_s;
  logic                lru_upd_s;
  logic                hit_evt_s;
  logic                miss_evt_s;
  logic                wr_hit_s;
  logic                wb_done_s;
  logic                fill_s;

  assign tag_s         = cpu_addr[31 -: TAG_BITS];
  assign idx_s         = cpu_addr[OFF_BITS +: SET_BITS];
  assign word_s        = cpu_addr[OFF_BITS-1:2];
  assign unused_addr_s = ^cpu_addr[1:0];
  assign req_s         = cpu_re | cpu_we;
  assign hit_s         = |hit_vec_s;
  assign hit_word_s    = data_mem[hit_way_s][idx_s][{word_s, 5'd0} +: 32];
  assign victim_dirty_s = valid_r[idx_s][victim_s] & dirty_r[idx_s][victim_s];
  assign hit_cnt       = hit_cnt_r;
  assign miss_cnt      = miss_cnt_r;

  // Tag compare across all ways of the indexed set; at most one way matches
  always_comb begin
    hit_vec_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_r[idx_s][w] && (tag_mem[w][idx_s] == tag_s);
      hit_way_s    = hit_vec_s[w] ? AW'(w) : hit_way_s;
    end
  end

  cache_lru_set #(
    .WAYS (WAYS),
    .AW   (AW)
  ) u_lru (
    .ages      (age_r[idx_s]),
    .valid     (valid_r[idx_s]),
    .touch     (touch_s),
    .ages_next (ages_next_s),
    .victim    (victim_s)
  );

  // Miss controller next-state and core handshake
  always_comb begin
    state_n    = state_r;
    cpu_ready  = 1'b0;
    cpu_rdata  = 32'd0;
    touch_s    = hit_way_s;
    lru_upd_s  = 1'b0;
    hit_evt_s  = 1'b0;
    miss_evt_s = 1'b0;
    wr_hit_s   = 1'b0;
    wb_done_s  = 1'b0;
    fill_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          cpu_ready = 1'b1;
          cpu_rdata = cpu_re ? hit_word_s : 32'd0;
          lru_upd_s = 1'b1;
          // the post-refill retry was already counted as a miss
          hit_evt_s = ~retry_r;
          wr_hit_s  = cpu_we;
        end else if (req_s) begin
          miss_evt_s = 1'b1;
          state_n    = victim_dirty_s ? WB : REFILL;
        end else begin
          state_n = IDLE;
        end
      end
      WB: begin
        if (mem_done) begin
          wb_done_s = 1'b1;
          state_n   = REFILL;
        end else begin
          state_n = WB;
        end
      end
      REFILL: begin
        if (mem_done) begin
          fill_s    = 1'b1;
          touch_s   = victim_r;
          lru_upd_s = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = REFILL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory port driven straight from the state register
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = 32'd0;
    mem_wblk = '0;
    case (state_r)
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_mem[victim_r][idx_s], idx_s, {OFF_BITS{1'b0}}};
        mem_wblk = data_mem[victim_r][idx_s];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_s, idx_s, {OFF_BITS{1'b0}}};
      end
      IDLE:    mem_req = 1'b0;
      default: mem_req = 1'b0;
    endcase
  end

  // Control state, line status bits, LRU ages and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      victim_r   <= '0;
      retry_r    <= 1'b0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_r[s][w*AW +: AW] <= AW'(w);
        end
      end
    end else begin
      state_r <= state_n;
      if (state_r == IDLE) begin
        victim_r <= victim_s;
      end
      retry_r <= fill_s ? 1'b1 : ((state_r == IDLE) ? 1'b0 : retry_r);
      if (hit_evt_s) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end
      if (miss_evt_s) begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
      if (lru_upd_s) begin
        age_r[idx_s] <= ages_next_s;
      end
      if (wr_hit_s) begin
        dirty_r[idx_s][hit_way_s] <= 1'b1;
      end
      if (wb_done_s) begin
        dirty_r[idx_s][victim_r] <= 1'b0;
      end
      if (fill_s) begin
        valid_r[idx_s][victim_r] <= 1'b1;
        dirty_r[idx_s][victim_r] <= 1'b0;
      end
    end
  end

  // Tag and data storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (wr_hit_s) begin
      data_mem[hit_way_s][idx_s][{word_s, 5'd0} +: 32] <= cpu_wdata;
    end
    if (fill_s) begin
      data_mem[victim_r][idx_s] <= mem_rblk;
      tag_mem[victim_r][idx_s]  <= tag_s;
    end
  end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Randomised scoreboard bench for cache_set_assoc: a recency-list cache model
// predicts core responses and memory transactions; monitors compare them.
module tb_cache_set_assoc;

  localparam int WAYS = 2;
  localparam int BLK_W = 256;

  logic clk, rst, cpu_re, cpu_we, cpu_ready, mem_req, mem_we, mem_done;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, hit_cnt, miss_cnt;
  logic [BLK_W-1:0] mem_wblk, mem_rblk;

  typedef struct packed { logic [31:0] tag; logic dirty; } mline_t;
  typedef struct packed { logic re; logic hit; logic [31:0] rdata; } sb_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [BLK_W-1:0] blk; } mop_t;

  mline_t lines_q [32][$];
  sb_t    sb_q[$];
  mop_t   mop_q[$];
  logic [31:0] backing [int unsigned];
  logic [31:0] view [int unsigned];
  int total = 0;
  int bad = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;
  bit hold_mem = 1'b0;

  cache_set_assoc #(.WAYS(2), .SET_BITS(5), .WORD_BITS(3)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wblk(mem_wblk),
    .mem_rblk(mem_rblk), .mem_done(mem_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] back_word(input logic [31:0] w);
    return backing.exists(w) ? backing[w] : ((w * 32'h9E37_79B9) ^ 32'h0F0F_0000);
  endfunction

  function automatic logic [31:0] view_word(input logic [31:0] w);
    return view.exists(w) ? view[w] : back_word(w);
  endfunction

  function automatic logic [BLK_W-1:0] view_block(input logic [31:0] baddr);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = view_word((baddr >> 2) + i);
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] back_block(input logic [31:0] baddr);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = back_word((baddr >> 2) + i);
    return r;
  endfunction

  // Each set is a recency list, front = most recently used.
  task automatic model_access(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] tag;
    int idx, pos;
    bit found;
    mline_t ln;
    sb_t e;
    mop_t m;
    tag = addr >> 10;
    idx = int'((addr >> 5) & 32'd31);
    found = 1'b0;
    pos = 0;
    for (int i = 0; i < lines_q[idx].size(); i++) begin
      if (!found && lines_q[idx][i].tag == tag) begin found = 1'b1; pos = i; end
    end
    if (found) begin
      ln = lines_q[idx][pos];
      lines_q[idx].delete(pos);
      exp_hits++;
    end else begin
      exp_misses++;
      if (lines_q[idx].size() == WAYS) begin
        ln = lines_q[idx].pop_back();
        if (ln.dirty) begin
          m.we = 1'b1;
          m.addr = (ln.tag << 10) | (32'(idx) << 5);
          m.blk = view_block(m.addr);
          mop_q.push_back(m);
        end
      end
      m.we = 1'b0;
      m.addr = addr & ~32'h1F;
      m.blk = '0;
      mop_q.push_back(m);
      ln.tag = tag;
      ln.dirty = 1'b0;
    end
    ln.dirty = ln.dirty | we;
    lines_q[idx].push_front(ln);
    if (we) view[addr >> 2] = wdata;
    e.re = re;
    e.hit = found;
    e.rdata = view_word(addr >> 2);
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 32; s++) lines_q[s].delete();
    view.delete();
    sb_q.delete();
    mop_q.delete();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic do_req(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    model_access(re, we, addr, wdata);
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 200);
    if (!cpu_ready) begin
      total++; bad++;
      $display("FAIL req_timeout: addr %h got no ready expected ready", addr);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "request timeout");
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  // Core-side monitor: pops the scoreboard whenever a request completes.
  int wait_cnt = 0;
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        wait_cnt = 0;
      end else if (cpu_re || cpu_we) begin
        if (cpu_ready) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected: got ready at addr %h expected none", cpu_addr);
          end else begin
            e = sb_q.pop_front();
            check("hit_latency", (wait_cnt == 0), e.hit);
            if (e.re) check("rdata", cpu_rdata, e.rdata);
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Memory responder: checks each transaction against the model and answers it.
  initial begin
    mop_t op;
    mem_done = 1'b0;
    mem_rblk = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst && !hold_mem) begin
        if (mop_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got txn we=%0d addr %h expected none", mem_we, mem_addr);
        end else begin
          op = mop_q.pop_front();
          check("mem_we", mem_we, op.we);
          check("mem_addr", mem_addr, op.addr);
          if (op.we) check("mem_wblk", mem_wblk, op.blk);
        end
        if (mem_we) begin
          for (int i = 0; i < 8; i++) backing[(mem_addr >> 2) + i] = mem_wblk[i*32 +: 32];
        end else begin
          mem_rblk = back_block(mem_addr);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        mem_rblk = '0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] addr;
    bit we;
    rst = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'd0;
    backing[32'h40 >> 2] = 32'h0000_1111;
    repeat (2) @(negedge clk);
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wblk", mem_wblk, '0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    cpu_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill, write, second-way fill, dirty eviction, LRU reorder.
    do_req(1'b1, 1'b0, 32'h40, 32'd0);
    check("t1_miss_cnt", miss_cnt, 32'd1);
    check("t1_hit_cnt", hit_cnt, 32'd0);
    do_req(1'b0, 1'b1, 32'h40, 32'h0000_DEAD);
    do_req(1'b1, 1'b0, 32'h40, 32'd0);
    do_req(1'b1, 1'b0, 32'h840, 32'd0);
    do_req(1'b1, 1'b0, 32'h1040, 32'd0);
    do_req(1'b1, 1'b0, 32'h840, 32'd0);
    do_req(1'b1, 1'b0, 32'h1840, 32'd0);
    do_req(1'b1, 1'b0, 32'h840, 32'd0);
    check("dir_hit_cnt", hit_cnt, exp_hits);
    check("dir_miss_cnt", miss_cnt, exp_misses);

    // Reset while a write-back is in flight.
    do_req(1'b0, 1'b1, 32'h80, 32'hAAAA_0001);
    do_req(1'b0, 1'b1, 32'h880, 32'hBBBB_0002);
    hold_mem = 1'b1;
    cpu_re = 1'b1; cpu_addr = 32'h1080;
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_req && mem_we) && n < 50);
    check("t5_wb_seen", mem_req & mem_we, 1'b1);
    check("t5_wb_addr", mem_addr, 32'h80);
    rst = 1'b1;
    #1;
    check("t5_mem_req", mem_req, 1'b0);
    check("t5_ready", cpu_ready, 1'b0);
    check("t5_hit_cnt", hit_cnt, 32'd0);
    check("t5_miss_cnt", miss_cnt, 32'd0);
    cpu_re = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    hold_mem = 1'b0;

    // Whole line: one miss, then back-to-back hits on every word.
    do_req(1'b1, 1'b0, 32'h80, 32'd0);
    for (int w = 0; w < 8; w++) do_req(1'b1, 1'b0, 32'h80 + 32'(w * 4), 32'd0);
    check("t6_hit_cnt", hit_cnt, 32'd8);
    check("t6_miss_cnt", miss_cnt, 32'd1);

    for (int i = 0; i < 400; i++) begin
      addr = (32'($urandom_range(0, 4)) << 10) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2);
      we = ($urandom_range(0, 2) == 0);
      do_req(!we, we, addr, $urandom);
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    repeat (3) @(negedge clk);
    check("end_hit_cnt", hit_cnt, exp_hits);
    check("end_miss_cnt", miss_cnt, exp_misses);
    check("end_sb_empty", 32'(sb_q.size()), 32'd0);
    check("end_mop_empty", 32'(mop_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
